// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code constants and the sequencer state type.
// The ALU result multiplexer uses the same constants for its case items.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL2   = 4'd2;
    localparam logic [3:0] OP_DIV2   = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_NOT    = 4'd7;
    localparam logic [3:0] OP_EQ     = 4'd8;
    localparam logic [3:0] OP_GT     = 4'd9;
    localparam logic [3:0] OP_LT     = 4'd10;
    localparam logic [3:0] OP_MAX    = 4'd11;
    localparam logic [3:0] OP_KNIGHT = 4'd12;

    localparam int NUM_OPS = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational function-code check; codes above the last defined op are illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output logic       legal
);

    assign legal = (op <= OP_KNIGHT);

endmodule

// File: rtl/alu_op_sequencer.sv
// One-at-a-time command front end for the 8-bit ALU: registers operands and
// select, waits SETTLE cycles, captures the ALU result and hands it back.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err,
    output logic             busy
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
        $error("alu_op_sequencer: SETTLE must be in 1..15");
    end

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    seq_state_t state;
    logic [3:0] cnt;
    logic       op_legal;

    alu_op_decode u_decode (
        .op    (cmd_op),
        .legal (op_legal)
    );

    // rst_n gating keeps cmd_ready low for the whole reset pulse.
    assign cmd_ready = rst_n && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 4'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (op_legal) begin
                            alu_a   <= cmd_a;
                            alu_b   <= cmd_b;
                            alu_sel <= cmd_op;
                            cnt     <= SETTLE_LOAD;
                            state   <= ST_SETTLE;
                        end else begin
                            res_data <= '0;
                            res_zero <= 1'b1;
                            res_err  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        res_data  <= alu_o;
                        res_zero  <= (alu_o == '0);
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // An illegal op arrives here with res_valid still low; it rises one cycle later.
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        res_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
